key_entry_dispatch: RTL and testbench
=====================================

// Module: key_entry_dispatch
// PURPOSE
//  Parametrised keypad number-entry and dispatch block. It accumulates decimal digits from
//  the matrix-keypad decoder into an entry buffer and, through a two-key commit sequence,
//  writes the value into one of NUM_CH setting registers (frequency, phase, amplitude, ...).
//  Sits between the keypad scanner and the DDS/control logic; entry_val drives the 7-seg display.
// PARAMETERS
//  NUM_CH      4    number of target setting registers (2..10)
//  VAL_W       20   width of entry buffer and each channel register
//  MAX_DIGITS  6    maximum decimal digits accepted per entry
//  CH_W        2    width of channel index; must be >= clog2(NUM_CH)
// PORTS
//  clk        in   1            system clock
//  rst        in   1            asynchronous reset, active-high
//  key_valid  in   1            1-cycle strobe: key_code is a new key press
//  key_code   in   4            0-9 digit, A commit, B backspace, C recall, E clear, D/F unused
//  entry_val  out  VAL_W        current entry buffer (to display)
//  digit_cnt  out  4            digits currently in entry buffer
//  sel_mode   out  1            1 while waiting for channel digit after A
//  ch_val     out  NUM_CH*VAL_W channel registers, ch0 in LSBs
//  ch_upd     out  NUM_CH       1-cycle pulse on the channel written
//  err        out  1            1-cycle pulse on rejected key
// BEHAVIOUR
//  Reset: entry_val=0, digit_cnt=0, sel_mode=0, all ch_val=0, ch_upd=0, err=0, state=S_IDLE.
//  Keys are acted on only in cycles with key_valid=1; ignored otherwise. All outputs registered,
//  1-cycle latency from the strobe edge; ch_upd/err high exactly one cycle.
//  States: S_IDLE (digit_cnt=0), S_ENTRY (digit_cnt>0), S_SEL (sel_mode=1).
//  S_IDLE/S_ENTRY:
//   - digit d: if digit_cnt<MAX_DIGITS: entry = entry*10+d, digit_cnt+1, go S_ENTRY.
//     entry*10 formed as (v<<3)+(v<<1) at VAL_W+4 bits; if result > 2^VAL_W-1, entry
//     saturates to all-ones, digit_cnt still increments, err pulses.
//     If digit_cnt==MAX_DIGITS: key dropped, err pulses, no change.
//     Leading zero in S_IDLE counts as a digit (entry stays 0, digit_cnt=1).
//   - B: entry = entry/10, digit_cnt-1; in S_IDLE: err, no change; reaching 0 digits -> S_IDLE.
//   - E: entry=0, digit_cnt=0 -> S_IDLE.
//   - A: in S_ENTRY -> S_SEL; in S_IDLE -> err, stay.
//   - C: next key must be a channel digit; modelled as S_SEL with recall flag set.
//  S_SEL:
//   - digit k < NUM_CH: commit -> ch_val[k]=entry, ch_upd[k] pulses, entry=0, digit_cnt=0 -> S_IDLE.
//     recall -> entry=ch_val[k], digit_cnt=MAX_DIGITS -> S_ENTRY; no ch_upd.
//   - digit k >= NUM_CH: err, stay S_SEL.
//   - E: abort, entry unchanged, return to S_ENTRY (S_IDLE if digit_cnt=0); recall flag cleared.
//   - any other key: err, stay S_SEL.
//  D/F: err in every state, no state change.
//  Only one channel register written per key; other channels hold.
//  Reset asserted mid-sequence (incl. S_SEL): everything returns to reset values immediately.
// TESTING
//  1. Reset, keys 1,2,3,4,5,6,7 -> entry 123456, digit_cnt 6, err pulse on 7th key, entry unchanged.
//  2. Keys 4,2,A,1 -> ch_val[1]=42, ch_upd=4'b0010 for one cycle, entry 0, S_IDLE.
//  3. Keys 9,8,B,B,B -> entry 98,9,0; third B: err pulse, digit_cnt 0.
//  4. Keys 5,A,7 (NUM_CH=4) -> err, sel_mode stays 1; then E -> entry 5, S_ENTRY.
//  5. After test 2: C,1 -> entry 42, digit_cnt 6, no ch_upd; A,3 -> ch_val[3]=42.
//  6. VAL_W=16: 6,5,5,3,6 -> entry 65535 saturated, err pulse; rst during S_SEL -> all cleared.

Source files
------------

// File: rtl/key_entry_dispatch.sv
// Keypad number-entry buffer: accumulates decimal digits, then commits or recalls
// the value to/from one of NUM_CH setting registers through a two-key sequence.
module key_entry_dispatch #(
  parameter int NUM_CH     = 4,
  parameter int VAL_W      = 20,
  parameter int MAX_DIGITS = 6,
  parameter int CH_W       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic [VAL_W-1:0]        entry_val,
  output logic [3:0]              digit_cnt,
  output logic                    sel_mode,
  output logic [NUM_CH*VAL_W-1:0] ch_val,
  output logic [NUM_CH-1:0]       ch_upd,
  output logic                    err
);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_SEL} state_t;

  localparam int              EXT_W   = VAL_W + 4;
  localparam logic [EXT_W-1:0] VAL_MAX = {4'd0, {VAL_W{1'b1}}};
  localparam logic [3:0]       MAX_CNT = 4'(MAX_DIGITS);

  state_t           state;
  logic             recall;
  logic [VAL_W-1:0] ch_reg [NUM_CH];

  logic [EXT_W-1:0] entry_ext;
  logic [EXT_W-1:0] times_ten;
  logic [EXT_W-1:0] appended;
  logic [VAL_W-1:0] entry_div10;
  logic [VAL_W-1:0] recall_val;
  logic [CH_W-1:0]  ch_idx;
  logic             is_digit;
  logic             ch_ok;

  // The 4 extra bits hold any entry*10+9, so overflow detection is a plain compare.
  always_comb begin
    entry_ext   = {4'd0, entry_val};
    times_ten   = (entry_ext << 3) + (entry_ext << 1);
    appended    = times_ten + {{(EXT_W-4){1'b0}}, key_code};
    entry_div10 = entry_val / VAL_W'(10);
    is_digit    = (key_code <= 4'd9);
    ch_ok       = is_digit && (32'(key_code) < NUM_CH);
    ch_idx      = CH_W'(key_code);
    recall_val  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_W'(i)) recall_val = ch_reg[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
    assign ch_val[g*VAL_W +: VAL_W] = ch_reg[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      recall    <= 1'b0;
      entry_val <= '0;
      digit_cnt <= '0;
      sel_mode  <= 1'b0;
      ch_upd    <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) ch_reg[i] <= '0;
    end else begin
      ch_upd <= '0;
      err    <= 1'b0;
      if (key_valid) begin
        case (state)
          S_IDLE, S_ENTRY: begin
            if (is_digit) begin
              if (digit_cnt >= MAX_CNT) begin
                err <= 1'b1;
              end else begin
                digit_cnt <= digit_cnt + 4'd1;
                state     <= S_ENTRY;
                if (appended > VAL_MAX) begin
                  entry_val <= '1;
                  err       <= 1'b1;
                end else begin
                  entry_val <= appended[VAL_W-1:0];
                end
              end
            end else begin
              case (key_code)
                4'hA: begin
                  if (state == S_ENTRY) begin
                    state    <= S_SEL;
                    sel_mode <= 1'b1;
                  end else begin
                    err <= 1'b1;
                  end
                end
                4'hB: begin
                  if (digit_cnt == 4'd0) begin
                    err <= 1'b1;
                  end else begin
                    entry_val <= entry_div10;
                    digit_cnt <= digit_cnt - 4'd1;
                    if (digit_cnt == 4'd1) state <= S_IDLE;
                  end
                end
                4'hC: begin
                  state    <= S_SEL;
                  sel_mode <= 1'b1;
                  recall   <= 1'b1;
                end
                4'hE: begin
                  entry_val <= '0;
                  digit_cnt <= '0;
                  state     <= S_IDLE;
                end
                default: err <= 1'b1;
              endcase
            end
          end
          S_SEL: begin
            if (ch_ok) begin
              sel_mode <= 1'b0;
              recall   <= 1'b0;
              if (recall) begin
                entry_val <= recall_val;
                digit_cnt <= MAX_CNT;
                state     <= S_ENTRY;
              end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                  if (ch_idx == CH_W'(i)) begin
                    ch_reg[i] <= entry_val;
                    ch_upd[i] <= 1'b1;
                  end
                end
                entry_val <= '0;
                digit_cnt <= '0;
                state     <= S_IDLE;
              end
            end else if (key_code == 4'hE) begin
              sel_mode <= 1'b0;
              recall   <= 1'b0;
              state    <= (digit_cnt == 4'd0) ? S_IDLE : S_ENTRY;
            end else begin
              err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_entry_dispatch.sv
// Directed bench for key_entry_dispatch: a default instance plus a VAL_W=16 instance
// for saturation, both fed the same key stream.
module tb_key_entry_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;

  logic [19:0] entry_a;
  logic [3:0]  cnt_a;
  logic        sel_a;
  logic [79:0] ch_a;
  logic [3:0]  upd_a;
  logic        err_a;

  logic [15:0] entry_b;
  logic [3:0]  cnt_b;
  logic        sel_b;
  logic [63:0] ch_b;
  logic [3:0]  upd_b;
  logic        err_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_entry_dispatch dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .entry_val(entry_a), .digit_cnt(cnt_a), .sel_mode(sel_a),
    .ch_val(ch_a), .ch_upd(upd_a), .err(err_a)
  );

  key_entry_dispatch #(.VAL_W(16)) dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .entry_val(entry_b), .digit_cnt(cnt_b), .sel_mode(sel_b),
    .ch_val(ch_b), .ch_upd(upd_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One-cycle strobe; returns at the following negedge with outputs updated.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_entry", entry_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_sel", sel_a, 0);
    check("rst_upd", upd_a, 0);
    check("rst_err", err_a, 0);
    for (int k = 0; k < 4; k++) check("rst_ch", ch_a[k*20 +: 20], 0);
    rst = 1'b0;

    // 1: digit limit
    press(4'd1); check("t1_first", entry_a, 1);
    press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'd6);
    check("t1_entry6", entry_a, 123456);
    check("t1_cnt6", cnt_a, 6);
    check("t1_noerr", err_a, 0);
    press(4'd7);
    check("t1_err7", err_a, 1);
    check("t1_entry7", entry_a, 123456);
    check("t1_cnt7", cnt_a, 6);
    idle_cycle();
    check("t1_errpulse", err_a, 0);
    press(4'hE);
    check("t1_clr_entry", entry_a, 0);
    check("t1_clr_cnt", cnt_a, 0);

    // 2: commit 42 to channel 1
    press(4'd4); press(4'd2);
    check("t2_entry", entry_a, 42);
    press(4'hA);
    check("t2_sel", sel_a, 1);
    check("t2_entry_held", entry_a, 42);
    press(4'd1);
    check("t2_upd", upd_a, 4'b0010);
    check("t2_ch1", ch_a[1*20 +: 20], 42);
    check("t2_ch0", ch_a[0*20 +: 20], 0);
    check("t2_ch2", ch_a[2*20 +: 20], 0);
    check("t2_entry0", entry_a, 0);
    check("t2_cnt0", cnt_a, 0);
    check("t2_sel0", sel_a, 0);
    // key_code without strobe must be ignored
    key_code = 4'd5;
    idle_cycle();
    check("t2_updpulse", upd_a, 0);
    check("t2_nostrobe", entry_a, 0);

    // 3: backspace down to empty
    press(4'd9); press(4'd8);
    check("t3_98", entry_a, 98);
    press(4'hB);
    check("t3_9", entry_a, 9);
    check("t3_cnt1", cnt_a, 1);
    press(4'hB);
    check("t3_0", entry_a, 0);
    check("t3_cnt0", cnt_a, 0);
    check("t3_noerr", err_a, 0);
    press(4'hB);
    check("t3_err", err_a, 1);
    check("t3_cnt_hold", cnt_a, 0);

    // 4: out-of-range channel, then abort
    press(4'd5); press(4'hA); press(4'd7);
    check("t4_err", err_a, 1);
    check("t4_sel", sel_a, 1);
    check("t4_noupd", upd_a, 0);
    press(4'hB);
    check("t4_bsel_err", err_a, 1);
    press(4'hE);
    check("t4_abort_entry", entry_a, 5);
    check("t4_abort_cnt", cnt_a, 1);
    check("t4_abort_sel", sel_a, 0);
    check("t4_abort_noerr", err_a, 0);
    press(4'd3);
    check("t4_entry_again", entry_a, 53);
    press(4'hD);
    check("t4_d_err", err_a, 1);
    check("t4_d_entry", entry_a, 53);
    press(4'hE);

    // leading zero and A from idle
    press(4'hA);
    check("idle_a_err", err_a, 1);
    check("idle_a_sel", sel_a, 0);
    press(4'd0);
    check("lead0_entry", entry_a, 0);
    check("lead0_cnt", cnt_a, 1);
    press(4'hE);

    // 5: recall channel 1, commit to channel 3
    press(4'hC);
    check("t5_sel", sel_a, 1);
    press(4'd1);
    check("t5_entry", entry_a, 42);
    check("t5_cnt", cnt_a, 6);
    check("t5_noupd", upd_a, 0);
    check("t5_sel0", sel_a, 0);
    press(4'hA); press(4'd3);
    check("t5_upd3", upd_a, 4'b1000);
    check("t5_ch3", ch_a[3*20 +: 20], 42);
    check("t5_ch1_hold", ch_a[1*20 +: 20], 42);

    // recall flag cleared by abort: next A,k is a commit
    press(4'hC); press(4'hE);
    check("abort_sel0", sel_a, 0);
    press(4'd4); press(4'hA); press(4'd2);
    check("recall_clr_upd", upd_a, 4'b0100);
    check("recall_clr_ch2", ch_a[2*20 +: 20], 4);

    // 6: saturation at VAL_W=16, then reset inside S_SEL
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    press(4'd6); press(4'd5); press(4'd5); press(4'd3);
    check("t6_b_6553", entry_b, 6553);
    press(4'd6);
    check("t6_b_sat", entry_b, 65535);
    check("t6_b_err", err_b, 1);
    check("t6_b_cnt", cnt_b, 5);
    check("t6_a_nosat", entry_a, 65536);
    check("t6_a_noerr", err_a, 0);
    press(4'hA);
    check("t6_b_sel", sel_b, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_sel", sel_b, 0);
    check("t6_rst_entry", entry_b, 0);
    check("t6_rst_cnt", cnt_b, 0);
    check("t6_rst_ch_a1", ch_a[1*20 +: 20], 0);
    check("t6_rst_ch_a3", ch_a[3*20 +: 20], 0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
